// File: rtl/ad9911_spi_writer.sv
// ad9911_spi_writer
// Single-register write engine for the AD9911 DDS. It accepts one command
// and shifts the instruction byte plus 1..4 data bytes MSB first on
// SCLK/SDIO0. It then optionally pulses IO_UPDATE. After reset it drives
// the DDS master-reset line for MRSET_WIDTH cycles before taking commands.
//
// Optional feature macro: AD9911_PPS_UPDATE_EN
//   When defined, a GPS_1PPS input is added. The IO_UPDATE pulse is then
//   held back until the first synchronised rising edge of the PPS signal
//   seen at or after the update phase begins.
//
// All outputs are registered. They are computed from the next-state values,
// so each output changes on the same edge as the state it belongs to.

module ad9911_spi_writer #(
  parameter int CLK_DIV      = 4,
  parameter int UPDATE_WIDTH = 4,
  parameter int MRSET_WIDTH  = 40
) (
  input  logic        CLOCK_40M,
  input  logic        RESET,
`ifdef AD9911_PPS_UPDATE_EN
  input  logic        GPS_1PPS,
`endif
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [1:0]  cmd_len,
  input  logic        cmd_update,
  output logic        busy,
  output logic        done,
  output logic        AD9911_SCLK,
  output logic        AD9911_SDIO0,
  output logic        AD9911_UPDATE,
  output logic        AD9911_MRSET
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMR_MAX = (MRSET_WIDTH > UPDATE_WIDTH) ? MRSET_WIDTH : UPDATE_WIDTH;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);
  localparam logic [TMR_W-1:0] MRST_LAST = TMR_W'(MRSET_WIDTH - 1);
  localparam logic [TMR_W-1:0] UPD_LAST  = TMR_W'(UPDATE_WIDTH - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = TMR_W'(0);

  typedef enum logic [2:0] {
    ST_MRST  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_UPD   = 3'd4
  } state_t;

  // The shift word is left-aligned in 40 bits. Bit 39 goes out first.
  // The instruction byte is a write (R/W = 0), two zero bits, then the
  // 5-bit address. The data bytes are the low 8*len bits of the payload.
  function automatic logic [39:0] build_word(input logic [4:0]  addr,
                                             input logic [31:0] data,
                                             input logic [1:0]  len);
    logic [7:0] instr;
    instr = {1'b0, 2'b00, addr};
    case (len)
      2'd1:    build_word = {instr, data[7:0],  24'h00_0000};
      2'd2:    build_word = {instr, data[15:0], 16'h0000};
      2'd3:    build_word = {instr, data[23:0], 8'h00};
      default: build_word = {instr, data[31:0]};
    endcase
  endfunction

  // Index of the final bit of the frame: N-1 with N = 8*(1+len).
  function automatic logic [5:0] last_bit_idx(input logic [1:0] len);
    case (len)
      2'd1:    last_bit_idx = 6'd15;
      2'd2:    last_bit_idx = 6'd23;
      2'd3:    last_bit_idx = 6'd31;
      default: last_bit_idx = 6'd39;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [39:0]        shreg_q, shreg_d;
  logic [5:0]         bit_q,   bit_d;
  logic [5:0]         last_q,  last_d;
  logic [DIV_W-1:0]   div_q,   div_d;
  logic [TMR_W-1:0]   tmr_q,   tmr_d;
  logic               upd_en_q, upd_en_d;
  logic               lead_q,  lead_d;

  logic               sclk_q,  sclk_d;
  logic               sdio_q,  sdio_d;
  logic               update_q, update_d;
  logic               mrset_q, mrset_d;
  logic               done_q,  done_d;
  logic               ready_q, ready_d;
  logic               busy_q,  busy_d;

  logic               accept_s;

`ifdef AD9911_PPS_UPDATE_EN
  logic pps_s1_q, pps_s2_q, pps_prev_q, pps_edge_q;
  logic wait_q, wait_d;

  // Bring GPS_1PPS into the clock domain and flag one rising edge.
  always_ff @(posedge CLOCK_40M) begin
    if (RESET) begin
      pps_s1_q   <= 1'b0;
      pps_s2_q   <= 1'b0;
      pps_prev_q <= 1'b0;
      pps_edge_q <= 1'b0;
    end else begin
      pps_s1_q   <= GPS_1PPS;
      pps_s2_q   <= pps_s1_q;
      pps_prev_q <= pps_s2_q;
      pps_edge_q <= pps_s2_q & ~pps_prev_q;
    end
  end
`endif

  assign accept_s = cmd_valid & ready_q;

  // Next-state, counters and registered-output values for the writer FSM.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    last_d   = last_q;
    div_d    = div_q;
    tmr_d    = tmr_q;
    upd_en_d = upd_en_q;
    lead_d   = lead_q;
    sclk_d   = sclk_q;
    sdio_d   = sdio_q;
    update_d = update_q;
    mrset_d  = 1'b0;
    done_d   = 1'b0;
`ifdef AD9911_PPS_UPDATE_EN
    wait_d   = wait_q;
`endif

    case (state_q)
      ST_MRST: begin
        sclk_d   = 1'b0;
        sdio_d   = 1'b0;
        update_d = 1'b0;
        if (tmr_q == MRST_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = TMR_ZERO;
          mrset_d = 1'b0;
        end else begin
          tmr_d   = tmr_q + TMR_ONE;
          mrset_d = 1'b1;
        end
      end

      ST_IDLE: begin
        sclk_d   = 1'b0;
        sdio_d   = 1'b0;
        update_d = 1'b0;
        if (accept_s) begin
          state_d  = ST_SHIFT;
          shreg_d  = build_word(cmd_addr, cmd_data, cmd_len);
          last_d   = last_bit_idx(cmd_len);
          upd_en_d = cmd_update;
          bit_d    = 6'd0;
          div_d    = DIV_ZERO;
          lead_d   = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (lead_q) begin
          // One cycle after acceptance, put the first bit on SDIO0.
          lead_d = 1'b0;
          sdio_d = shreg_q[39];
          div_d  = DIV_ZERO;
        end else if (div_q != DIV_LAST) begin
          div_d  = div_q + DIV_ONE;
        end else begin
          div_d = DIV_ZERO;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: move to the next bit, or finish the frame.
            sclk_d = 1'b0;
            if (bit_q == last_q) begin
              state_d = ST_GAP;
              sdio_d  = 1'b0;
            end else begin
              bit_d   = bit_q + 6'd1;
              shreg_d = {shreg_q[38:0], 1'b0};
              sdio_d  = shreg_q[38];
            end
          end
        end
      end

      ST_GAP: begin
        sclk_d = 1'b0;
        sdio_d = 1'b0;
        if (div_q == DIV_LAST) begin
          div_d = DIV_ZERO;
          if (upd_en_q) begin
            state_d  = ST_UPD;
            tmr_d    = TMR_ZERO;
`ifdef AD9911_PPS_UPDATE_EN
            update_d = 1'b0;
            wait_d   = 1'b1;
`else
            update_d = 1'b1;
`endif
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      ST_UPD: begin
        sclk_d = 1'b0;
        sdio_d = 1'b0;
`ifdef AD9911_PPS_UPDATE_EN
        if (wait_q) begin
          if (pps_edge_q) begin
            wait_d   = 1'b0;
            update_d = 1'b1;
            tmr_d    = TMR_ZERO;
          end else begin
            wait_d   = 1'b1;
            update_d = 1'b0;
          end
        end else if (tmr_q == UPD_LAST) begin
          update_d = 1'b0;
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          tmr_d    = TMR_ZERO;
        end else begin
          tmr_d    = tmr_q + TMR_ONE;
        end
`else
        if (tmr_q == UPD_LAST) begin
          update_d = 1'b0;
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          tmr_d    = TMR_ZERO;
        end else begin
          tmr_d    = tmr_q + TMR_ONE;
        end
`endif
      end

      default: begin
        state_d  = ST_MRST;
        tmr_d    = TMR_ZERO;
        sclk_d   = 1'b0;
        sdio_d   = 1'b0;
        update_d = 1'b0;
        mrset_d  = 1'b1;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, datapath and output registers; RESET restarts the MRST sequence.
  always_ff @(posedge CLOCK_40M) begin
    if (RESET) begin
      state_q  <= ST_MRST;
      shreg_q  <= 40'h00_0000_0000;
      bit_q    <= 6'd0;
      last_q   <= 6'd0;
      div_q    <= DIV_ZERO;
      tmr_q    <= TMR_ZERO;
      upd_en_q <= 1'b0;
      lead_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdio_q   <= 1'b0;
      update_q <= 1'b0;
      mrset_q  <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
`ifdef AD9911_PPS_UPDATE_EN
      wait_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      last_q   <= last_d;
      div_q    <= div_d;
      tmr_q    <= tmr_d;
      upd_en_q <= upd_en_d;
      lead_q   <= lead_d;
      sclk_q   <= sclk_d;
      sdio_q   <= sdio_d;
      update_q <= update_d;
      mrset_q  <= mrset_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef AD9911_PPS_UPDATE_EN
      wait_q   <= wait_d;
`endif
    end
  end

  assign cmd_ready     = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign AD9911_SCLK   = sclk_q;
  assign AD9911_SDIO0  = sdio_q;
  assign AD9911_UPDATE = update_q;
  assign AD9911_MRSET  = mrset_q;

endmodule

// File: tb/tb_ad9911_spi_writer.sv
// Self-checking bench for ad9911_spi_writer (CLK_DIV=2, UPDATE_WIDTH=4,
// MRSET_WIDTH=40). Expected frames and timings come from a byte-level
// model of the write protocol.
`timescale 1ns/1ps

module tb_ad9911_spi_writer;

  localparam int CD = 2;
  localparam int UW = 4;
  localparam int MW = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_addr = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [1:0]  cmd_len = 2'd0;
  logic        cmd_update = 1'b0;
  logic        busy, done, sclk, sdio, upd, mrset;
  logic        gps = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  ad9911_spi_writer #(.CLK_DIV(CD), .UPDATE_WIDTH(UW), .MRSET_WIDTH(MW)) dut (
    .CLOCK_40M     (clk),
    .RESET         (rst),
`ifdef AD9911_PPS_UPDATE_EN
    .GPS_1PPS      (gps),
`endif
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .cmd_len       (cmd_len),
    .cmd_update    (cmd_update),
    .busy          (busy),
    .done          (done),
    .AD9911_SCLK   (sclk),
    .AD9911_SDIO0  (sdio),
    .AD9911_UPDATE (upd),
    .AD9911_MRSET  (mrset)
  );

  always #5 clk = ~clk;

  // DDS-side view: the bits sampled on SCLK rises, SDIO changes while SCLK is high, UPDATE-high cycles and done pulses.
  bit   rx_q[$];
  logic sclk_prev = 1'b0;
  logic sdio_prev = 1'b0;
  int   glitch = 0;
  int   upd_cnt = 0;
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (sclk === 1'b1 && sclk_prev !== 1'b1) rx_q.push_back(sdio);
    if (sclk === 1'b1 && sclk_prev === 1'b1 && sdio !== sdio_prev) glitch++;
    if (upd === 1'b1) upd_cnt++;
    if (done === 1'b1) done_cnt++;
    sclk_prev = sclk;
    sdio_prev = sdio;
  end

  // Wait for cmd_ready, present a command, and pass the acceptance edge.
  task automatic issue(input logic [4:0] a, input logic [31:0] d,
                       input logic [1:0] l, input logic u, input string nm);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: cmd_ready=%b expected 1", nm, cmd_ready);
    end
    cmd_addr   = a;
    cmd_data   = d;
    cmd_len    = l;
    cmd_update = u;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
  endtask

  // Observe one transfer from the acceptance edge to done and compare it with the model.
  task automatic measure(input logic [4:0] a, input logic [31:0] d,
                         input logic [1:0] l, input logic u, input string nm);
    logic [7:0] bytes [5];
    int nb, nbits, c, rise_c, exp_rise, exp_done, lo, hi;
    int rx0, g0, u0, busy_err, ready_err, bit_err;
    bit seen;
    nb    = (l == 2'd0) ? 4 : int'(l);
    nbits = 8 * (nb + 1);
    bytes[0] = {3'b000, a};
    for (int i = 0; i < nb; i++) bytes[1 + i] = 8'((d >> (8 * (nb - 1 - i))) & 32'hFF);
    exp_rise = 1 + 2 * CD * nbits + CD;
    exp_done = u ? exp_rise + UW : exp_rise;
    lo = exp_rise;
    hi = exp_rise;
`ifdef AD9911_PPS_UPDATE_EN
    lo = exp_rise + 100 + 3;
    hi = exp_rise + 100 + 4;
`endif
    rx0 = rx_q.size();
    g0  = glitch;
    u0  = upd_cnt;
    busy_err = 0;
    ready_err = 0;
    seen = 1'b0;
    rise_c = -1;
    c = 0;
    @(negedge clk);
    while (done !== 1'b1 && c < 3000) begin
      if (busy !== 1'b1) busy_err++;
      if (cmd_ready !== 1'b0) ready_err++;
      if (upd === 1'b1 && !seen) begin
        seen = 1'b1;
        rise_c = c;
      end
`ifdef AD9911_PPS_UPDATE_EN
      if (u && c == exp_rise + 100) gps = 1'b1;
`endif
      @(negedge clk);
      c++;
    end
    #1;
`ifdef AD9911_PPS_UPDATE_EN
    if (u) exp_done = rise_c + UW;
    gps = 1'b0;
`endif
    n_tests++;
    if (c != exp_done) begin
      n_fail++;
      $display("FAIL %s_done_cycle: got %0d expected %0d", nm, c, exp_done);
    end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_at_done: got %b expected 1", nm, cmd_ready);
    end
    n_tests++;
    if (rx_q.size() - rx0 != nbits) begin
      n_fail++;
      $display("FAIL %s_rise_count: got %0d expected %0d", nm, rx_q.size() - rx0, nbits);
    end
    bit_err = 0;
    for (int k = 0; k < nbits && rx0 + k < rx_q.size(); k++)
      if (rx_q[rx0 + k] != bytes[k / 8][7 - (k % 8)]) bit_err++;
    n_tests++;
    if (bit_err != 0) begin
      n_fail++;
      $display("FAIL %s_stream: %0d wrong bits, expected frame %h %h %h %h %h (first %0d bytes)",
               nm, bit_err, bytes[0], bytes[1], bytes[2], bytes[3], bytes[4], nb + 1);
    end
    n_tests++;
    if (seen !== u) begin
      n_fail++;
      $display("FAIL %s_update_seen: got %b expected %b", nm, seen, u);
    end
    if (u) begin
      n_tests++;
      if (rise_c < lo || rise_c > hi) begin
        n_fail++;
        $display("FAIL %s_update_rise: got cycle %0d expected %0d..%0d", nm, rise_c, lo, hi);
      end
    end
    n_tests++;
    if (upd_cnt - u0 != (u ? UW : 0)) begin
      n_fail++;
      $display("FAIL %s_update_len: got %0d expected %0d", nm, upd_cnt - u0, u ? UW : 0);
    end
    n_tests++;
    if (glitch != g0) begin
      n_fail++;
      $display("FAIL %s_sdio_stable: got %0d changes while SCLK high expected 0", nm, glitch - g0);
    end
    n_tests++;
    if (busy_err != 0 || ready_err != 0) begin
      n_fail++;
      $display("FAIL %s_busy_ready: busy low %0d cycles, ready high %0d cycles, expected 0/0",
               nm, busy_err, ready_err);
    end
  endtask

  // Hold RESET for three edges, check reset values, and measure the MRSET pulse.
  task automatic test_reset(input string nm);
    int cnt;
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({cmd_ready, busy, done, sclk, sdio, upd, mrset} !== 7'b0100001) begin
      n_fail++;
      $display("FAIL %s_values: ready,busy,done,sclk,sdio,upd,mrset=%b expected 0100001",
               nm, {cmd_ready, busy, done, sclk, sdio, upd, mrset});
    end
    rst = 1'b0;
    cnt = 1;
    @(negedge clk);
    while (mrset === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (cnt != MW) begin
      n_fail++;
      $display("FAIL %s_mrset_len: got %0d expected %0d", nm, cnt, MW);
    end
    n_tests++;
    if ({cmd_ready, busy, sclk, upd} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s_idle: ready,busy,sclk,upd=%b expected 1000", nm, {cmd_ready, busy, sclk, upd});
    end
  endtask

  task automatic test_full_ftw();
    issue(5'h04, 32'h1999999A, 2'd0, 1'b1, "ftw");
    measure(5'h04, 32'h1999999A, 2'd0, 1'b1, "ftw");
  endtask

  task automatic test_short_write();
    issue(5'h00, 32'h000000F2, 2'd1, 1'b0, "short");
    measure(5'h00, 32'h000000F2, 2'd1, 1'b0, "short");
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  l;
    logic        u;
    for (int i = 0; i < 8; i++) begin
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      l = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      issue(a, d, l, u, "rand");
      measure(a, d, l, u, "rand");
    end
  endtask

  // Keep cmd_valid high with a second command during a transfer.
  task automatic test_back_to_back();
    logic [4:0]  a2;
    logic [31:0] d2;
    a2 = 5'($urandom_range(0, 31));
    d2 = $urandom;
    issue(5'h0A, 32'hA5C3_0F96, 2'd3, 1'b0, "hold_a");
    cmd_addr   = a2;
    cmd_data   = d2;
    cmd_len    = 2'd2;
    cmd_update = 1'b1;
    cmd_valid  = 1'b1;
    measure(5'h0A, 32'hA5C3_0F96, 2'd3, 1'b0, "hold_a");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 5'h1F;
    cmd_data  = 32'hFFFF_FFFF;
    cmd_len   = 2'd0;
    measure(a2, d2, 2'd2, 1'b1, "hold_b");
  endtask

  // Reset after the 10th SCLK rise: immediate reset values, no done, no further SCLK.
  task automatic test_midshift_reset();
    int rx0, d0, t, cnt;
    issue(5'h05, 32'h1234_5678, 2'd0, 1'b1, "mid");
    rx0 = rx_q.size();
    d0  = done_cnt;
    t = 0;
    while (rx_q.size() - rx0 < 10 && t < 1000) begin
      @(negedge clk);
      #1;
      t++;
    end
    n_tests++;
    if (rx_q.size() - rx0 != 10) begin
      n_fail++;
      $display("FAIL mid_reach10: got %0d rises expected 10", rx_q.size() - rx0);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({sclk, upd, mrset, done, busy, cmd_ready} !== 6'b001010) begin
      n_fail++;
      $display("FAIL mid_reset_values: sclk,upd,mrset,done,busy,ready=%b expected 001010",
               {sclk, upd, mrset, done, busy, cmd_ready});
    end
    rst = 1'b0;
    cnt = 1;
    @(negedge clk);
    while (mrset === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    #1;
    n_tests++;
    if (cnt != MW) begin
      n_fail++;
      $display("FAIL mid_mrset_len: got %0d expected %0d", cnt, MW);
    end
    n_tests++;
    if (rx_q.size() - rx0 != 10 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL mid_quiet: rises %0d done pulses %0d expected 10 and 0",
               rx_q.size() - rx0, done_cnt - d0);
    end
    issue(5'h06, 32'h0000_BEEF, 2'd2, 1'b0, "after_mid");
    measure(5'h06, 32'h0000_BEEF, 2'd2, 1'b0, "after_mid");
  endtask

  initial begin
    test_reset("reset");
    test_full_ftw();
    test_short_write();
    test_random();
    test_back_to_back();
    test_midshift_reset();
    test_reset("reset2");
    test_short_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9911_spi_writer.md
# ad9911_spi_writer

Serial register writer for the AD9911 DDS (LO and RF channels use one instance each). It accepts single register-write commands from the control logic on the AD/RF board and serialises them MSB-first over single-bit SPI (SCLK, SDIO0). It then optionally pulses IO_UPDATE. Its outputs drive the COM_AD_RF_AD9911_*_SCLK / _SDIO0 / _UPDATE / _MRSET connector lines consumed by the DDS board, where CS and PD are tied low.

## Interface
- CLK_DIV, 4: SCLK half-period in clock cycles (≥1); 5 MHz SCLK at 40 MHz.
- UPDATE_WIDTH, 4: IO_UPDATE high time in clock cycles (≥1).
- MRSET_WIDTH, 40: master-reset pulse length in clock cycles after reset (≥1).

Ports (one clock; reset is synchronous and active-high):
- CLOCK_40M  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; the command is accepted on cmd_valid && cmd_ready.
- cmd_addr  in  5  AD9911 register address.
- cmd_data  in  32  payload; the lowest 8·len bits are sent, MSB first.
- cmd_len  in  2  payload byte count; values 1–3 are literal, 0 means 4.
- cmd_update  in  1  when 1, pulse IO_UPDATE after the shift.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the command completes.
- AD9911_SCLK  out  1  serial clock, idles low.
- AD9911_SDIO0  out  1  serial data.
- AD9911_UPDATE  out  1  IO_UPDATE.
- AD9911_MRSET  out  1  master reset, active high.

## Operation
- States: MRST → IDLE → SHIFT → GAP → (UPD) → IDLE.
- **MRST:** entered on RESET. MRSET is held high for MRSET_WIDTH cycles, then the block goes to IDLE. No command is accepted in MRST.
- **IDLE:** cmd_ready = 1. On acceptance, the block latches the command and builds a shift word.
  - Instruction byte = {1'b0 (write), 2'b00, cmd_addr}, followed by len data bytes.
  - N = 8·(1+len) bits, so N ∈ {16, 24, 32, 40}.
- **SHIFT:** bit k (k = 0..N-1) is sent MSB first.
  - SDIO0 changes only while SCLK is low.
  - SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - The DDS samples SDIO0 on the SCLK rising edge.
- **GAP:** SCLK and SDIO0 low for CLK_DIV cycles. Then:
  - go to UPD if the latched update bit = 1;
  - otherwise go to IDLE and pulse done.
- **UPD:** UPDATE is high for UPDATE_WIDTH cycles, then the block goes to IDLE and pulses done.
- cmd_* inputs are ignored while busy. They are latched only at acceptance.
- Reset values: cmd_ready 0, busy 1, done 0, SCLK 0, SDIO0 0, UPDATE 0, MRSET 1.

## Timing
- Cycle 0 is the acceptance edge.
- Bit k:
  - SDIO0 valid from cycle 1+2·CLK_DIV·k;
  - SCLK rises at 1+2·CLK_DIV·k+CLK_DIV;
  - SCLK falls at 1+2·CLK_DIV·(k+1).
- The last SCLK falling edge is followed by GAP (CLK_DIV cycles), then UPD (UPDATE_WIDTH cycles) if selected.
- done is high on the cycle the FSM re-enters IDLE, and cmd_ready is high in that same cycle. Back-to-back commands therefore have exactly one IDLE cycle between them.
- Command latency with update = 1 + 2·CLK_DIV·N + CLK_DIV + UPDATE_WIDTH cycles to done.
- Exactly N SCLK rising edges are produced per command, with no glitches.
- RESET mid-operation:
  - the next cycle shows the reset values (SCLK low, UPDATE low, MRSET high);
  - the partial transfer is discarded;
  - the MRST sequence restarts in full;
  - no done pulse is produced.
- Counters are sized from the parameters. The bit counter covers 0..39, and the divider counter covers 0..CLK_DIV-1 and wraps to 0.

## Configuration
- AD9911_PPS_UPDATE_EN
  - **Defined:** adds input GPS_1PPS (1 bit). It passes through a two-flop synchroniser, and a rising edge is detected on the synchronised copy. In UPD, UPDATE is held low until the first detected edge at or after UPD entry, then goes high for UPDATE_WIDTH cycles. busy stays high while waiting. This aligns frequency changes to GPS time.
  - **Undefined:** the port is absent and UPD asserts UPDATE on entry.

## Test plan
All scenarios use CLK_DIV=2, UPDATE_WIDTH=4, MRSET_WIDTH=40.
- **Reset sequence:** pulse RESET for 3 cycles → MRSET high for 40 cycles after release, then cmd_ready=1, busy=0, SCLK=0, UPDATE=0.
- **Full FTW write:** addr 0x04, data 0x1999999A, len 0, update 1 → 40 SCLK rises sample bytes 04 19 99 99 9A. UPDATE high for 4 cycles. done at cycle 1+160+2+4 = 167.
- **Short write:** addr 0x00, data 0x000000F2, len 1, update 0 → 16 rises sample 00 F2. UPDATE never asserts. done at cycle 1+64+2 = 67.
- **Busy hold-off:** hold cmd_valid high with new values during a transfer → cmd_ready stays 0 and the serial stream is unchanged. The second command is accepted on the done cycle, and the next transfer's first bit follows one cycle later.
- **Mid-shift reset:** assert RESET after the 10th SCLK rise → the next cycle shows SCLK=0, MRSET=1, no done. Sampling at the DDS sees no further SCLK edge until a new command.
- **PPS option (macro defined):** command with update 1, GPS_1PPS rising 100 cycles after GAP ends → UPDATE rises 3–4 cycles after the pin edge and lasts 4 cycles. done follows, and busy stays high throughout the wait.
